// File: rtl/requant_unit.sv
// requant_unit: TFLite-style int8 requantization of a signed 32-bit accumulator stream,
// packing four result bytes per 32-bit output word (little-endian lanes).
// Build option: define REQUANT_PER_CHANNEL_EN for a MAX_CH-entry per-channel mult/shift
// table; otherwise a single mult/shift register serves every channel.

module requant_unit #(
  parameter int unsigned MAX_CH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_addr,
  input  logic [31:0] cfg_mult,
  input  logic [5:0]  cfg_shift,
  input  logic        start,
  input  logic [8:0]  num_ch,
  input  logic [7:0]  out_zp,
  input  logic [7:0]  act_min,
  input  logic [7:0]  act_max,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_acc,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_strb,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e      r_state, w_state_next;

  // Job configuration latched on start
  logic [7:0]  r_last_ch, r_zp, r_act_min, r_act_max;
  logic [7:0]  r_ch_idx;

  // Pipeline registers
  logic        r_s1_valid, r_s1_last;
  logic [31:0] r_s1_a, r_s1_mult;
  logic [5:0]  r_s1_shift;
  logic        r_s2_valid, r_s2_last;
  logic [31:0] r_s2_x;
  logic [5:0]  r_s2_shift;
  logic        r_s3_valid, r_s3_last;
  logic [7:0]  r_s3_byte;

  // Packer and output register
  logic [1:0]  r_pack_cnt;
  logic [23:0] r_pack_data;
  logic        r_out_valid, r_out_last;
  logic [31:0] r_out_data;
  logic [3:0]  r_out_strb;

  logic        w_adv, w_accept, w_out_fire, w_start;
  logic [31:0] w_tbl_mult;
  logic [5:0]  w_tbl_shift;
  logic        w_unused_misc;

  // Whole pipeline moves only when the output register can take a new word
  assign w_adv      = !(r_out_valid && !out_ready);
  assign in_ready   = (r_state == StRun) && w_adv;
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_start    = (r_state == StIdle) && start;

  assign busy      = (r_state != StIdle);
  assign done      = (r_state == StDone);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_strb  = r_out_strb;
  assign out_last  = r_out_last;

`ifdef REQUANT_PER_CHANNEL_EN
  logic [31:0] r_mult_tbl  [MAX_CH];
  logic [5:0]  r_shift_tbl [MAX_CH];

  // Table write, not reset; writes are blocked during a job
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      r_mult_tbl[cfg_addr]  <= cfg_mult;
      r_shift_tbl[cfg_addr] <= cfg_shift;
    end
  end

  assign w_tbl_mult    = r_mult_tbl[r_ch_idx];
  assign w_tbl_shift   = r_shift_tbl[r_ch_idx];
  // num_ch values 0 and 256 both mean 256 channels, so bit 8 never matters
  assign w_unused_misc = num_ch[8];
`else
  logic [31:0] r_mult;
  logic [5:0]  r_shift;

  // Shared mult/shift register, not reset; writes are blocked during a job
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      r_mult  <= cfg_mult;
      r_shift <= cfg_shift;
    end
  end

  assign w_tbl_mult    = r_mult;
  assign w_tbl_shift   = r_shift;
  assign w_unused_misc = ^{num_ch[8], cfg_addr, 32'(MAX_CH)};
`endif

  // S1: optional left shift before the multiply (32-bit wrap)
  logic [31:0] w_s1_a;
  assign w_s1_a = ($signed(w_tbl_shift) > 6'sd0) ? (in_acc << w_tbl_shift[4:0]) : in_acc;

  // S2: saturating rounding doubling high multiply
  logic signed [63:0] w_a64, w_m64, w_p, w_nudge, w_sum;
  logic               w_round_up, w_sat;
  logic [31:0]        w_s2_x;
  assign w_a64      = {{32{r_s1_a[31]}}, r_s1_a};
  assign w_m64      = {{32{r_s1_mult[31]}}, r_s1_mult};
  assign w_p        = w_a64 * w_m64;
  assign w_nudge    = w_p[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000;
  assign w_sum      = w_p + w_nudge;
  // Arithmetic shift floors; bump negative inexact results to truncate toward zero
  assign w_round_up = w_sum[63] && (w_sum[30:0] != 31'd0);
  assign w_sat      = (r_s1_a == 32'h8000_0000) && (r_s1_mult == 32'h8000_0000);
  assign w_s2_x     = w_sat ? 32'h7FFF_FFFF : (w_sum[62:31] + {31'd0, w_round_up});

  // S3: rounding right shift, zero-point add, activation clamp
  logic [5:0]         w_r;
  logic [31:0]        w_mask, w_rem, w_thr, w_sra, w_y;
  logic signed [32:0] w_zsum, w_min33, w_max33;
  logic [7:0]         w_s3_byte;
  assign w_r       = 6'd0 - r_s2_shift;
  assign w_mask    = (32'd1 << w_r) - 32'd1;
  assign w_rem     = r_s2_x & w_mask;
  assign w_thr     = (w_mask >> 1) + {31'd0, r_s2_x[31]};
  assign w_sra     = $unsigned($signed(r_s2_x) >>> w_r);
  assign w_y       = r_s2_shift[5] ? (w_sra + {31'd0, (w_rem > w_thr)}) : r_s2_x;
  assign w_zsum    = $signed({w_y[31], w_y}) + $signed({{25{r_zp[7]}}, r_zp});
  assign w_min33   = $signed({{25{r_act_min[7]}}, r_act_min});
  assign w_max33   = $signed({{25{r_act_max[7]}}, r_act_max});
  assign w_s3_byte = (w_zsum < w_min33) ? r_act_min :
                     (w_zsum > w_max33) ? r_act_max : w_zsum[7:0];

  // Packer: place the S3 byte in its lane; emit on a full word or the last byte
  logic        w_emit;
  logic [31:0] w_word;
  logic [3:0]  w_strb;
  assign w_emit = (r_pack_cnt == 2'd3) || r_s3_last;
  assign w_word = {8'd0, r_pack_data} | ({24'd0, r_s3_byte} << {r_pack_cnt, 3'b000});
  assign w_strb = {r_pack_cnt == 2'd3, r_pack_cnt >= 2'd2, r_pack_cnt != 2'd0, 1'b1};

  // Next-state logic for the job FSM
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StRun;
      StRun:   if (w_accept && in_last) w_state_next = StFlush;
      StFlush: if (w_out_fire && r_out_last && !r_s1_valid && !r_s2_valid && !r_s3_valid)
                 w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Job configuration capture and channel index bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_ch <= 8'd0;
      r_zp      <= 8'd0;
      r_act_min <= 8'd0;
      r_act_max <= 8'd0;
      r_ch_idx  <= 8'd0;
    end else if (w_start) begin
      r_last_ch <= num_ch[7:0] - 8'd1;  // 0 and 256 both wrap to 255
      r_zp      <= out_zp;
      r_act_min <= act_min;
      r_act_max <= act_max;
      r_ch_idx  <= 8'd0;
    end else if (w_accept) begin
      r_ch_idx  <= (r_ch_idx == r_last_ch) ? 8'd0 : r_ch_idx + 8'd1;
    end
  end

  // Three-stage datapath, all stages advancing together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_a     <= 32'd0;
      r_s1_mult  <= 32'd0;
      r_s1_shift <= 6'd0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_x     <= 32'd0;
      r_s2_shift <= 6'd0;
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
      r_s3_byte  <= 8'd0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      r_s1_last  <= in_last;
      r_s1_a     <= w_s1_a;
      r_s1_mult  <= w_tbl_mult;
      r_s1_shift <= w_tbl_shift;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_x     <= w_s2_x;
      r_s2_shift <= r_s1_shift;
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
      r_s3_byte  <= w_s3_byte;
    end
  end

  // Partial-word accumulator; cleared after each emitted word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pack_cnt  <= 2'd0;
      r_pack_data <= 24'd0;
    end else if (w_start) begin
      r_pack_cnt  <= 2'd0;
      r_pack_data <= 24'd0;
    end else if (w_adv && r_s3_valid) begin
      if (w_emit) begin
        r_pack_cnt  <= 2'd0;
        r_pack_data <= 24'd0;
      end else begin
        r_pack_cnt  <= r_pack_cnt + 2'd1;
        r_pack_data <= w_word[23:0];
      end
    end
  end

  // Output register; holds its word stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_strb  <= 4'd0;
      r_out_last  <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s3_valid && w_emit;
      if (r_s3_valid && w_emit) begin
        r_out_data <= w_word;
        r_out_strb <= w_strb;
        r_out_last <= r_s3_last;
      end
    end
  end

endmodule

// File: tb/tb_requant_unit.sv
// Self-checking bench for requant_unit: directed vectors, a randomised backpressure run
// against a reference model, and a mid-job reset. Honours REQUANT_PER_CHANNEL_EN.

module tb_requant_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [31:0] cfg_mult = '0;
  logic [5:0]  cfg_shift = '0;
  logic        start = 1'b0;
  logic [8:0]  num_ch = '0;
  logic [7:0]  out_zp = '0, act_min = '0, act_max = '0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [31:0] in_acc = '0;
  logic        in_ready;
  logic        out_valid, out_last, busy, done;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_strb;

  requant_unit #(.MAX_CH(256)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mult(cfg_mult),
    .cfg_shift(cfg_shift), .start(start), .num_ch(num_ch), .out_zp(out_zp),
    .act_min(act_min), .act_max(act_max), .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_strb(out_strb), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  bit rnd_ready = 1'b0;

  // Scoreboard entries: {last, strb, data}
  logic [36:0] exp_q[$];

  // Reference model state
  logic [31:0] m_mult  [256];
  logic [5:0]  m_shift [256];
  int          m_ch, j_nch;
  logic [7:0]  j_zp, j_min, j_max;
  int          pk_cnt;
  logic [31:0] pk_word;
  logic [3:0]  pk_strb;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] acc, input logic [31:0] mult,
                                          input logic [5:0] sh, input logic [7:0] zp,
                                          input logic [7:0] amin, input logic [7:0] amax);
    int s, r, xi;
    logic [31:0] a;
    longint sa, sm, p, nudge, x, ax, q, y, v, lo, hi, sz;
    s = $signed(sh);
    a = (s > 0) ? (acc << s) : acc;
    if (a == 32'h8000_0000 && mult == 32'h8000_0000) begin
      x = 64'sd2147483647;
    end else begin
      sa = $signed(a);
      sm = $signed(mult);
      p = sa * sm;
      nudge = (p >= 0) ? 64'sd1073741824 : 64'sd1 - 64'sd1073741824;
      x = (p + nudge) / 64'sd2147483648;
      xi = int'(x);
      x = xi;
    end
    if (s < 0) begin
      r = -s;
      ax = (x < 0) ? -x : x;
      q = (ax + (64'sd1 <<< (r - 1))) >>> r;
      y = (x < 0) ? -q : q;
    end else begin
      y = x;
    end
    sz = $signed(zp);
    lo = $signed(amin);
    hi = $signed(amax);
    v = y + sz;
    if (v < lo) v = lo;
    else if (v > hi) v = hi;
    return v[7:0];
  endfunction

  task automatic push_exp(input logic [31:0] data, input logic [3:0] strb, input logic last);
    exp_q.push_back({last, strb, data});
  endtask

  task automatic push_byte(input logic [7:0] b, input logic last);
    pk_word = pk_word | ({24'd0, b} << (8 * pk_cnt));
    pk_strb = pk_strb | (4'b0001 << pk_cnt);
    if (pk_cnt == 3 || last) begin
      push_exp(pk_word, pk_strb, last);
      pk_cnt = 0;
      pk_word = '0;
      pk_strb = '0;
    end else begin
      pk_cnt++;
    end
  endtask

  // All driving tasks start and end at 1 time unit after a rising edge
  task automatic cfg_write(input logic [7:0] addr, input logic [31:0] mult, input logic [5:0] sh,
                           input bit model_upd);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_mult = mult;
    cfg_shift = sh;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (model_upd) begin
`ifdef REQUANT_PER_CHANNEL_EN
      m_mult[addr] = mult;
      m_shift[addr] = sh;
`else
      for (int i = 0; i < 256; i++) begin
        m_mult[i] = mult;
        m_shift[i] = sh;
      end
`endif
    end
  endtask

  task automatic cfg_all(input logic [31:0] mult, input logic [5:0] sh);
    for (int i = 0; i < 4; i++) cfg_write(8'(i), mult, sh, 1'b1);
  endtask

  task automatic start_job(input logic [8:0] n, input logic [7:0] zp, input logic [7:0] amin,
                           input logic [7:0] amax);
    num_ch = n;
    out_zp = zp;
    act_min = amin;
    act_max = amax;
    start = 1'b1;
    j_nch = (n == 9'd0) ? 256 : int'(n);
    j_zp = zp;
    j_min = amin;
    j_max = amax;
    m_ch = 0;
    pk_cnt = 0;
    pk_word = '0;
    pk_strb = '0;
    @(negedge clk);
    check_val("in_ready_before_start", in_ready, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the job inputs so a design that fails to latch them is exposed
    num_ch = 9'd3;
    out_zp = 8'h55;
    act_min = 8'h7F;
    act_max = 8'h80;
    @(negedge clk);
    check_val("in_ready_after_start", in_ready, 1'b1);
    check_val("busy_after_start", busy, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [31:0] acc, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_acc = acc;
    in_last = last;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_val("in_ready_wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] acc, input logic last);
    push_byte(ref_byte(acc, m_mult[m_ch], m_shift[m_ch], j_zp, j_min, j_max), last);
    m_ch = (m_ch + 1 == j_nch) ? 0 : m_ch + 1;
    send_beat(acc, last);
  endtask

  task automatic wait_done();
    int t = 0;
    int d0 = done_cnt;
    @(negedge clk);
    while (!done && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_val("done_pulse", done, 1'b1);
    check_val("busy_in_done", busy, 1'b1);
    @(negedge clk);
    check_val("done_cleared", done, 1'b0);
    check_val("busy_fall", busy, 1'b0);
    check_val("done_count", 64'(done_cnt - d0), 64'd1);
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 1'b0);
    check_val({tag, "_out_valid"}, out_valid, 1'b0);
    check_val({tag, "_out_data"}, out_data, 32'd0);
    check_val({tag, "_out_strb"}, out_strb, 4'd0);
    check_val({tag, "_out_last"}, out_last, 1'b0);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_done"}, done, 1'b0);
  endtask

  task automatic job_basic();
    cfg_all(32'h4000_0000, 6'd0);
    start_job(9'd4, 8'd0, 8'h80, 8'h7F);
    push_exp(32'h7F7F_CE32, 4'hF, 1'b1);
    send_beat(32'd100, 1'b0);
    send_beat(-32'sd100, 1'b0);
    send_beat(32'd254, 1'b0);
    send_beat(32'd300, 1'b1);
    // Word completes at the third edge after acceptance
    repeat (3) @(negedge clk);
    check_val("latency_not_early", out_valid, 1'b0);
    @(negedge clk);
    check_val("latency_on_time", out_valid, 1'b1);
    wait_done();
  endtask

  // Scoreboard consumer: compare each accepted output word in order
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("sb_extra_word", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_val("out_data", out_data, e[31:0]);
        check_val("out_strb", out_strb, e[35:32]);
        check_val("out_last", out_last, e[36]);
      end
    end
    if (rst_n && done) done_cnt++;
  end

  // out_ready source: held high, or toggled randomly during the stress job
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] acc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Half multiplier, no shift, saturating clamp
    job_basic();

    // Rounding right shift by 2, short last word
    cfg_all(32'h4000_0000, 6'h3E);
    start_job(9'd4, 8'd0, 8'h80, 8'h7F);
    push_exp(32'h0000_F30D, 4'h3, 1'b1);
    send_beat(32'd100, 1'b0);
    send_beat(-32'sd100, 1'b1);
    wait_done();

    // Left shift, zero point 10, ReLU-style clamp
    cfg_all(32'h7FFF_FFFF, 6'd1);
    start_job(9'd4, 8'd10, 8'd10, 8'h7F);
    push_exp(32'h0000_320A, 4'h3, 1'b1);
    send_beat(-32'sd5, 1'b0);
    send_beat(32'd20, 1'b1);
    wait_done();

    // Saturating doubling-multiply corner
    cfg_all(32'h8000_0000, 6'd0);
    start_job(9'd4, 8'd0, 8'h80, 8'h7F);
    push_exp(32'h0000_9C7F, 4'h3, 1'b1);
    send_beat(32'h8000_0000, 1'b0);
    send_beat(32'd100, 1'b1);
    wait_done();

    // Two channels with distinct multipliers
    cfg_write(8'd0, 32'h4000_0000, 6'd0, 1'b1);
    cfg_write(8'd1, 32'h2000_0000, 6'd0, 1'b1);
    start_job(9'd2, 8'd0, 8'h80, 8'h7F);
`ifdef REQUANT_PER_CHANNEL_EN
    push_exp(32'h0A14_0A14, 4'hF, 1'b1);
`else
    push_exp(32'h0A0A_0A0A, 4'hF, 1'b1);
`endif
    for (int i = 0; i < 4; i++) send_beat(32'd40, i == 3);
    wait_done();

    // Random backpressure over 64 beats, 5 channels, model-driven expectations
    for (int i = 0; i < 5; i++)
      cfg_write(8'(i), $urandom, 6'($urandom_range(0, 16)) - 6'd8, 1'b1);
    start_job(9'd5, 8'($urandom), 8'hA0, 8'h60);
    // Writes during a job must be ignored
    cfg_write(8'd0, 32'h1234_5678, 6'd5, 1'b0);
    rnd_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      acc = (i % 3 == 0) ? $urandom : ($urandom_range(0, 2000) - 32'd1000);
      send_model(acc, i == 63);
    end
    wait_done();
    rnd_ready = 1'b0;

    // Reset with three beats in flight, then a clean job
    cfg_all(32'h4000_0000, 6'd0);
    start_job(9'd4, 8'd0, 8'h80, 8'h7F);
    send_beat(32'd10, 1'b0);
    send_beat(32'd20, 1'b0);
    send_beat(32'd30, 1'b0);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midjob_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    job_basic();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
